seq_shifter: RTL and testbench

Multi-cycle, parametrised shift unit for the RISC-V datapath ALU; the successor to the single-cycle arithmetic right shifter. Supports logical left, logical right and arithmetic right shifts of a WIDTH-bit operand by a register-supplied amount. Shifts by at most STEP bits per clock to keep logic depth low. Sits beside the ALU behind a valid/ready handshake, so the control unit can stall on it like any other multi-cycle unit.

---
 rtl/seq_shifter.sv | 227 ++++++++++++++++++++++
 tb/tb_seq_shifter.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_shifter.sv
// seq_shifter: multi-cycle shift unit (SLL / SRL / SRA, optional ROR) for the
// ALU datapath. A request is taken on the in_valid/in_ready handshake. The
// operand is then shifted by at most STEP bits per clock until the latched
// amount is used up, and the result is offered on out_valid/out_ready.
//
// Optional feature macro: SEQ_SHIFTER_ROTATE_EN
//   defined   -> op=2'b11 performs rotate right
//   undefined -> the rotate datapath is not built and op=2'b11 acts as SRL
//
// in_ready and out_valid come from flops loaded with the next-state decode, so
// neither output has a combinational path from any input. result is the data
// register itself.

module seq_shifter #(
  parameter  int WIDTH = 32,
  parameter  int STEP  = 4,
  localparam int SW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [SW-1:0]    shamt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_SRA = 2'b10,
    OP_ROR = 2'b11
  } op_e;

  // STEP can equal WIDTH, which does not fit in SW bits. It is therefore
  // compared in SW+1 bits. It is only used as a shift amount when it is
  // smaller than rem, and rem is at most WIDTH-1.
  localparam logic [SW:0] STEP_LIM = (SW+1)'(STEP);

  state_e           state_r;
  state_e           state_s;
  op_e              op_r;
  logic [WIDTH-1:0] data_r;
  logic [WIDTH-1:0] data_next_s;
  logic [SW-1:0]    rem_r;
  logic [SW-1:0]    rem_next_s;
  logic [SW-1:0]    step_s;
  logic             sign_r;
  logic             accept_s;
  logic             in_ready_r;
  logic             out_valid_r;

  // Right shift by k. The vacated MSBs are loaded with 'fill'. The fill mask is
  // built by shifting an all-ones word, so k=0 gives an empty mask.
  function automatic logic [WIDTH-1:0] shift_right_fill(
    input logic [WIDTH-1:0] d,
    input logic [SW-1:0]    k,
    input logic             fill
  );
    logic [WIDTH-1:0] mask;
    mask = ~({WIDTH{1'b1}} >> k);
    if (fill) begin
      return (d >> k) | mask;
    end else begin
      return d >> k;
    end
  endfunction

`ifdef SEQ_SHIFTER_ROTATE_EN
  // Rotate right by k. Shift a doubled copy of the word and keep the low half,
  // so the bits leaving the LSB re-enter at the MSB.
  function automatic logic [WIDTH-1:0] rotate_right(
    input logic [WIDTH-1:0] d,
    input logic [SW-1:0]    k
  );
    logic [2*WIDTH-1:0] dbl;
    dbl = {d, d} >> k;
    return dbl[WIDTH-1:0];
  endfunction
`endif

  // Bits to move this clock: k = min(rem, STEP).
  always_comb begin
    step_s = rem_r;
    if ({1'b0, rem_r} > STEP_LIM) begin
      step_s = STEP_LIM[SW-1:0];
    end else begin
      step_s = rem_r;
    end
  end

  // Remaining count after this clock's step.
  always_comb begin
    rem_next_s = rem_r - step_s;
  end

  // One partial shift of the data register, using the fill rule of the
  // latched op.
  always_comb begin
    data_next_s = data_r;
    case (op_r)
      OP_SLL:  data_next_s = data_r << step_s;
      OP_SRL:  data_next_s = shift_right_fill(data_r, step_s, 1'b0);
      OP_SRA:  data_next_s = shift_right_fill(data_r, step_s, sign_r);
`ifdef SEQ_SHIFTER_ROTATE_EN
      OP_ROR:  data_next_s = rotate_right(data_r, step_s);
`else
      OP_ROR:  data_next_s = shift_right_fill(data_r, step_s, 1'b0);
`endif
      default: data_next_s = data_r;
    endcase
  end

  // A request is taken only while idle.
  always_comb begin
    accept_s = 1'b0;
    if (state_r == IDLE) begin
      accept_s = in_valid;
    end else begin
      accept_s = 1'b0;
    end
  end

  // Next-state logic. The current step may consume the last of rem, and the
  // unit then moves to DONE. Because of this, shamt=0 still spends one SHIFT
  // clock.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          state_s = SHIFT;
        end else begin
          state_s = IDLE;
        end
      end
      SHIFT: begin
        if (rem_next_s == {SW{1'b0}}) begin
          state_s = DONE;
        end else begin
          state_s = SHIFT;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // State register. Reset discards any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Handshake flags are registered decodes of the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      in_ready_r  <= (state_s == IDLE);
      out_valid_r <= (state_s == DONE);
    end
  end

  // Datapath. Operands are captured on the accept edge only. The data
  // register shifts during SHIFT and holds in DONE and IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_r <= {WIDTH{1'b0}};
      rem_r  <= {SW{1'b0}};
      op_r   <= OP_SLL;
      sign_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            data_r <= a;
            rem_r  <= shamt;
            op_r   <= op_e'(op);
            sign_r <= a[WIDTH-1];
          end else begin
            data_r <= data_r;
            rem_r  <= rem_r;
            op_r   <= op_r;
            sign_r <= sign_r;
          end
        end
        SHIFT: begin
          data_r <= data_next_s;
          rem_r  <= rem_next_s;
        end
        DONE: begin
          data_r <= data_r;
          rem_r  <= rem_r;
        end
        default: begin
          data_r <= data_r;
          rem_r  <= rem_r;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign result    = data_r;

endmodule

// File: tb/tb_seq_shifter.sv
// Self-checking bench for seq_shifter. It applies directed scenarios and
// randomized requests. Expected results come from whole-word shift operators,
// and expected latency comes from ceil(shamt/STEP).

module tb_seq_shifter;

  localparam int W    = 32;
  localparam int STEP = 4;
  localparam int SW   = $clog2(W);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [1:0]    op = 2'b00;
  logic [W-1:0]  a = '0;
  logic [SW-1:0] shamt = '0;
  logic          in_ready;
  logic          out_valid;
  logic [W-1:0]  result;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  seq_shifter #(.WIDTH(W), .STEP(STEP)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .shamt     (shamt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
  );

  // Reference: whole-word shift in one step.
  function automatic logic [W-1:0] ref_shift(input logic [1:0] o, input logic [W-1:0] x, input int s);
    logic signed [W-1:0] sx;
    sx = x;
    case (o)
      2'b00:   return x << s;
      2'b01:   return x >> s;
      2'b10:   return sx >>> s;
`ifdef SEQ_SHIFTER_ROTATE_EN
      default: return (s == 0) ? x : ((x >> s) | (x << (W - s)));
`else
      default: return x >> s;
`endif
    endcase
  endfunction

  function automatic int ref_lat(input int s);
    return (s == 0) ? 1 : (s + STEP - 1) / STEP;
  endfunction

  // Issue one request, count edges until out_valid, take the result.
  task automatic run_op(input logic [1:0] o, input logic [W-1:0] x, input int s,
                        output logic [W-1:0] res, output int lat);
    int wait_cyc;
    wait_cyc = 0;
    while (!in_ready && wait_cyc < 50) begin
      @(posedge clk); #1; wait_cyc++;
    end
    op = o; a = x; shamt = SW'(s); in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    // Scramble the operands after accept; the unit must ignore them.
    op = 2'($urandom); a = $urandom; shamt = SW'($urandom);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    res = result;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    vectors++;
    if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    vectors++;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    vectors++;
    if (result !== '0) begin miscompares++; $display("FAIL reset_result: got %h expected 0", result); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      miscompares++; $display("FAIL post_reset_idle: got in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_sra_positive();
    logic [W-1:0] res; int lat;
    run_op(2'b10, 32'h0FFA05FF, 10, res, lat);
    vectors++;
    if (res !== 32'h0003FE81) begin miscompares++; $display("FAIL sra_pos_result: got %h expected 0003fe81", res); end
    vectors++;
    if (lat !== 3) begin miscompares++; $display("FAIL sra_pos_latency: got %0d expected 3", lat); end
  endtask

  task automatic test_modes();
    logic [W-1:0] res; int lat;
    logic [W-1:0] exp_tab [3];
    exp_tab[0] = 32'h00000000; exp_tab[1] = 32'h0F000000; exp_tab[2] = 32'hFF000000;
    for (int i = 0; i < 3; i++) begin
      run_op(2'(i), 32'hF0000000, 4, res, lat);
      vectors++;
      if (res !== exp_tab[i]) begin miscompares++; $display("FAIL mode_op%0d: got %h expected %h", i, res, exp_tab[i]); end
    end
    run_op(2'b11, 32'h0000000F, 4, res, lat);
    vectors++;
`ifdef SEQ_SHIFTER_ROTATE_EN
    if (res !== 32'hF0000000) begin miscompares++; $display("FAIL mode_op3: got %h expected f0000000", res); end
`else
    if (res !== 32'h00000000) begin miscompares++; $display("FAIL mode_op3: got %h expected 00000000", res); end
`endif
  endtask

  task automatic test_boundary();
    logic [W-1:0] res; int lat;
    for (int i = 0; i < 4; i++) begin
      run_op(2'(i), 32'h12345678, 0, res, lat);
      vectors++;
      if (res !== 32'h12345678 || lat !== 1) begin
        miscompares++; $display("FAIL shamt0_op%0d: got %h lat %0d expected 12345678 lat 1", i, res, lat);
      end
    end
    run_op(2'b10, 32'h80000000, 31, res, lat);
    vectors++;
    if (res !== 32'hFFFFFFFF || lat !== 8) begin
      miscompares++; $display("FAIL shamt31_sra: got %h lat %0d expected ffffffff lat 8", res, lat);
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] x, expv; int n;
    x = $urandom;
    expv = ref_shift(2'b01, x, 7);
    op = 2'b01; a = x; shamt = SW'(7); in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 100) begin @(posedge clk); #1; n++; end
    for (int c = 0; c < 5; c++) begin
      vectors++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== expv) begin
        miscompares++;
        $display("FAIL backpressure_c%0d: got ov=%b ir=%b res=%h expected 1/0/%h", c, out_valid, in_ready, result, expv);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      miscompares++; $display("FAIL backpressure_release: got ir=%b ov=%b expected 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] res, x; int lat;
    op = 2'b00; a = $urandom; shamt = SW'(20); in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || result !== '0 || in_ready !== 1'b1) begin
      miscompares++; $display("FAIL reset_mid: got ov=%b res=%h ir=%b expected 0/0/1", out_valid, result, in_ready);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    x = $urandom;
    run_op(2'b10, x, 13, res, lat);
    vectors++;
    if (res !== ref_shift(2'b10, x, 13) || lat !== ref_lat(13)) begin
      miscompares++; $display("FAIL reset_mid_fresh: got %h lat %0d expected %h lat %0d", res, lat, ref_shift(2'b10, x, 13), ref_lat(13));
    end
  endtask

  task automatic test_random();
    logic [W-1:0] res, x; logic [1:0] o; int s, lat;
    for (int i = 0; i < 300; i++) begin
      o = 2'($urandom); x = $urandom; s = $urandom_range(0, W - 1);
      run_op(o, x, s, res, lat);
      vectors++;
      if (res !== ref_shift(o, x, s) || lat !== ref_lat(s)) begin
        miscompares++;
        $display("FAIL random_%0d op%0d a=%h sh=%0d: got %h lat %0d expected %h lat %0d",
                 i, o, x, s, res, lat, ref_shift(o, x, s), ref_lat(s));
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] bop [4]; logic [W-1:0] ba [4]; int bs [4];
    logic [W-1:0] exp_q [$]; int acc_cyc [$]; int gap_q [$];
    logic [W-1:0] e;
    int idx, cyc, got; logic accepting;
    for (int i = 0; i < 4; i++) begin
      bop[i] = 2'($urandom); ba[i] = $urandom; bs[i] = $urandom_range(0, W - 1);
    end
    idx = 0; cyc = 0; got = 0;
    out_ready = 1'b1;
    op = bop[0]; a = ba[0]; shamt = SW'(bs[0]); in_valid = 1'b1;
    while (got < 4 && cyc < 200) begin
      accepting = 1'b0;
      if (in_ready && in_valid) begin
        exp_q.push_back(ref_shift(bop[idx], ba[idx], bs[idx]));
        acc_cyc.push_back(cyc);
        gap_q.push_back(ref_lat(bs[idx]) + 2);
        accepting = 1'b1;
      end
      @(posedge clk); #1; cyc++;
      if (accepting) begin
        idx++;
        if (idx < 4) begin
          op = bop[idx]; a = ba[idx]; shamt = SW'(bs[idx]);
        end else begin
          in_valid = 1'b0;
        end
      end
      if (out_valid) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        vectors++;
        if (result !== e) begin miscompares++; $display("FAIL b2b_result_%0d: got %h expected %h", got, result, e); end
        got++;
      end
    end
    vectors++;
    if (got !== 4) begin miscompares++; $display("FAIL b2b_count: got %0d expected 4", got); end
    for (int i = 1; i < acc_cyc.size(); i++) begin
      vectors++;
      if (acc_cyc[i] - acc_cyc[i-1] !== gap_q[i-1]) begin
        miscompares++; $display("FAIL b2b_gap_%0d: got %0d expected %0d", i, acc_cyc[i] - acc_cyc[i-1], gap_q[i-1]);
      end
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_sra_positive();
    test_modes();
    test_boundary();
    test_backpressure();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
